// File: rtl/sqscmul_sched_pkg.sv
// Shared types and width helpers for the GF(4) square-scale-multiply issue scheduler.
package sqscmul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int unsigned lat_f(input int unsigned pipelined);
    return (pipelined != 0) ? 1 : 0;
  endfunction

  function automatic int unsigned share_w_f(input int unsigned shares);
    return 4 * shares;
  endfunction

  function automatic int unsigned z_w_f(input int unsigned shares);
    return 2 * shares * (shares - 1);
  endfunction

endpackage

// File: rtl/sqscmul_rsp_fifo.sv
// In-order response FIFO holding requester id plus masked result; data is zero while empty.
module sqscmul_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IDW   = 1,
  parameter int unsigned DW    = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [IDW-1:0]             i_push_id,
  input  logic [DW-1:0]              i_push_q,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [IDW-1:0]             o_id,
  output logic [DW-1:0]              o_q,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDW-1:0] r_id [DEPTH];
  logic [DW-1:0]  r_q  [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_id[r_wr_ptr] <= i_push_id;
      r_q[r_wr_ptr]  <= i_push_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_id    = o_valid ? r_id[r_rd_ptr] : '0;
  assign o_q     = o_valid ? r_q[r_rd_ptr]  : '0;
  assign o_count = r_count;

endmodule

// File: rtl/sqscmul_gf4_sched.sv
// Issue scheduler for one shared masked GF(4) square-scale-multiply unit.
// SQSCMUL_RR_ARB_EN selects round-robin arbitration; otherwise lowest index wins.
module sqscmul_gf4_sched
  import sqscmul_sched_pkg::*;
#(
  parameter int unsigned SHARES    = 2,
  parameter int unsigned PIPELINED = 1,
  parameter int unsigned NREQ      = 2,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                             ClkxCI,
  input  logic                             RstxRI,
  input  logic                             EnxSI,
  output logic                             IdlexSO,
  input  logic [NREQ-1:0]                  ReqValidxSI,
  output logic [NREQ-1:0]                  ReqReadyxSO,
  input  logic [NREQ*4*SHARES-1:0]         ReqXxDI,
  input  logic [NREQ*4*SHARES-1:0]         ReqYxDI,
  input  logic                             RndValidxSI,
  output logic                             RndReadyxSO,
  input  logic [2*SHARES*(SHARES-1)-1:0]   RndxDI,
  output logic [4*SHARES-1:0]              MulXxDO,
  output logic [4*SHARES-1:0]              MulYxDO,
  output logic [2*SHARES*(SHARES-1)-1:0]   MulZxDO,
  input  logic [4*SHARES-1:0]              MulQxDI,
  output logic                             RspValidxSO,
  input  logic                             RspReadyxSI,
  output logic [$clog2(NREQ)-1:0]          RspIdxDO,
  output logic [4*SHARES-1:0]              RspQxDO
);

  localparam int unsigned LAT = lat_f(PIPELINED);
  localparam int unsigned SW  = share_w_f(SHARES);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);

  state_e         r_state;
  state_e         w_state_nxt;
  logic           w_any_req;
  logic           w_credit_ok;
  logic           w_fire;
  logic [IDW-1:0] w_gnt;
  logic [IDW-1:0] w_start;
  logic [CW-1:0]  w_fifo_cnt;
  logic [CW-1:0]  w_inflight;
  logic [CW:0]    w_used;
  logic           w_tag_exit;
  logic [IDW-1:0] w_tag_exit_id;

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (EnxSI) w_state_nxt = RUN;
      RUN:     if (!EnxSI) w_state_nxt = DRAIN;
      DRAIN:   if ((w_inflight == '0) && (w_fifo_cnt == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign IdlexSO = (r_state == IDLE);

`ifdef SQSCMUL_RR_ARB_EN
  logic [IDW-1:0] r_ptr;

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI)      r_ptr <= '0;
    else if (w_fire) r_ptr <= (32'(w_gnt) == NREQ - 1) ? '0 : w_gnt + 1'b1;
  end

  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif

  // First valid requester at or after w_start, wrapping around
  always_comb begin
    w_any_req = 1'b0;
    w_gnt     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!w_any_req && ReqValidxSI[j] && (((32'(w_start) + i) % NREQ) == j)) begin
          w_any_req = 1'b1;
          w_gnt     = IDW'(j);
        end
      end
    end
  end

  // Everything issued but not yet popped holds a FIFO slot in reserve
  assign w_used      = {1'b0, w_fifo_cnt} + {1'b0, w_inflight};
  assign w_credit_ok = (w_used < (CW+1)'(RSP_DEPTH));
  assign w_fire      = (r_state == RUN) && w_any_req && RndValidxSI && w_credit_ok;

  always_comb begin
    ReqReadyxSO = '0;
    RndReadyxSO = 1'b0;
    MulXxDO     = '0;
    MulYxDO     = '0;
    MulZxDO     = '0;
    if (w_fire) begin
      RndReadyxSO = 1'b1;
      MulZxDO     = RndxDI;
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (w_gnt == IDW'(r)) begin
          ReqReadyxSO[r] = 1'b1;
          MulXxDO        = ReqXxDI[r*SW +: SW];
          MulYxDO        = ReqYxDI[r*SW +: SW];
        end
      end
    end
  end

  generate
    if (LAT == 0) begin : g_lat0
      assign w_tag_exit    = w_fire;
      assign w_tag_exit_id = w_gnt;
      assign w_inflight    = '0;
    end else begin : g_latn
      logic [LAT-1:0]          r_tag_vld;
      logic [LAT-1:0][IDW-1:0] r_tag_id;

      always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
          r_tag_vld <= '0;
          r_tag_id  <= '0;
        end else begin
          r_tag_vld[0] <= w_fire;
          r_tag_id[0]  <= w_gnt;
          for (int unsigned i = 1; i < LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_id[i]  <= r_tag_id[i-1];
          end
        end
      end

      always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < LAT; i++) w_inflight = w_inflight + CW'(r_tag_vld[i]);
      end

      assign w_tag_exit    = r_tag_vld[LAT-1];
      assign w_tag_exit_id = r_tag_id[LAT-1];
    end
  endgenerate

  sqscmul_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .IDW   (IDW),
    .DW    (SW)
  ) u_rsp_fifo (
    .i_clk     (ClkxCI),
    .i_rst     (RstxRI),
    .i_push    (w_tag_exit),
    .i_push_id (w_tag_exit_id),
    .i_push_q  (MulQxDI),
    .i_pop     (RspReadyxSI),
    .o_valid   (RspValidxSO),
    .o_id      (RspIdxDO),
    .o_q       (RspQxDO),
    .o_count   (w_fifo_cnt)
  );

endmodule

// File: tb/tb_sqscmul_gf4_sched.sv
// Randomized bench for sqscmul_gf4_sched with a transaction-level reference model.
module tb_sqscmul_gf4_sched;

  localparam int unsigned SHARES    = 2;
  localparam int unsigned PIPELINED = 1;
  localparam int unsigned NREQ      = 2;
  localparam int unsigned RSP_DEPTH = 2;
  localparam int unsigned LAT       = (PIPELINED != 0) ? 1 : 0;
  localparam int unsigned SW        = 4 * SHARES;
  localparam int unsigned ZW        = 2 * SHARES * (SHARES - 1);
  localparam int unsigned IDW       = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic                  idle;
  logic [NREQ-1:0]       req_vld = '0;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*SW-1:0]    req_x = '0;
  logic [NREQ*SW-1:0]    req_y = '0;
  logic                  rnd_vld = 1'b0;
  logic                  rnd_rdy;
  logic [ZW-1:0]         rnd = '0;
  logic [SW-1:0]         mul_x;
  logic [SW-1:0]         mul_y;
  logic [ZW-1:0]         mul_z;
  logic [SW-1:0]         mul_q = '0;
  logic                  rsp_vld;
  logic                  rsp_rdy = 1'b0;
  logic [IDW-1:0]        rsp_id;
  logic [SW-1:0]         rsp_q;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         id;
    logic [3:0] res;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   m_state = 0;   // 0 idle, 1 run, 2 drain
  int   m_ptr   = 0;
  int   cyc     = 0;

  sqscmul_gf4_sched #(
    .SHARES    (SHARES),
    .PIPELINED (PIPELINED),
    .NREQ      (NREQ),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .ClkxCI      (clk),
    .RstxRI      (rst),
    .EnxSI       (en),
    .IdlexSO     (idle),
    .ReqValidxSI (req_vld),
    .ReqReadyxSO (req_rdy),
    .ReqXxDI     (req_x),
    .ReqYxDI     (req_y),
    .RndValidxSI (rnd_vld),
    .RndReadyxSO (rnd_rdy),
    .RndxDI      (rnd),
    .MulXxDO     (mul_x),
    .MulYxDO     (mul_y),
    .MulZxDO     (mul_z),
    .MulQxDI     (mul_q),
    .RspValidxSO (rsp_vld),
    .RspReadyxSI (rsp_rdy),
    .RspIdxDO    (rsp_id),
    .RspQxDO     (rsp_q)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] sqmul(input logic [3:0] x, input logic [3:0] y);
    return gf_mul(gf_mul(x, x), y);
  endfunction

  function automatic logic [3:0] recomb(input logic [SW-1:0] v);
    return v[3:0] ^ v[7:4];
  endfunction

  // Stand-in for the masked multiplier: one register stage, output re-masked with Z
  always @(posedge clk) begin
    mul_q <= {mul_z[3:0], sqmul(recomb(mul_x), recomb(mul_y)) ^ mul_z[3:0]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int arb_pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (start + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int r, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] mx;
    logic [3:0] my;
    mx = 4'($urandom);
    my = 4'($urandom);
    req_x[r*SW +: SW] = {mx ^ x, mx};
    req_y[r*SW +: SW] = {my ^ y, my};
  endtask

  task automatic drive(input logic e, input logic [NREQ-1:0] v, input logic rv, input logic rr);
    en      = e;
    req_vld = v;
    rnd_vld = rv;
    rsp_rdy = rr;
    rnd     = ZW'($urandom);
    for (int r = 0; r < NREQ; r++) set_req(r, 4'($urandom), 4'($urandom));
  endtask

  // One clock: compare outputs at the falling edge, then advance the model
  task automatic tick();
    int   g;
    int   start;
    int   nstate;
    bit   fire;
    bit   ev;
    exp_t e;
    @(negedge clk);
`ifdef SQSCMUL_RR_ARB_EN
    start = m_ptr;
`else
    start = 0;
`endif
    g    = arb_pick(req_vld, start);
    fire = (m_state == 1) && (g >= 0) && rnd_vld && (exp_q.size() < RSP_DEPTH);
    chk("idle", 32'(idle), 32'(m_state == 0));
    chk("req_ready", 32'(req_rdy), fire ? (32'd1 << g) : 32'd0);
    chk("rnd_ready", 32'(rnd_rdy), 32'(fire));
    chk("mul_x", 32'(mul_x), fire ? 32'(req_x[g*SW +: SW]) : 32'd0);
    chk("mul_y", 32'(mul_y), fire ? 32'(req_y[g*SW +: SW]) : 32'd0);
    chk("mul_z", 32'(mul_z), fire ? 32'(rnd) : 32'd0);
    ev = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    chk("rsp_valid", 32'(rsp_vld), 32'(ev));
    if (ev) begin
      chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
      chk("rsp_q", 32'(recomb(rsp_q)), 32'(exp_q[0].res));
    end else begin
      chk("rsp_q_empty", 32'(rsp_q), 32'd0);
    end
    nstate = m_state;
    case (m_state)
      0: if (en) nstate = 1;
      1: if (!en) nstate = 2;
      default: if (exp_q.size() == 0) nstate = 0;
    endcase
    if (ev && rsp_rdy) void'(exp_q.pop_front());
    if (fire) begin
      e.id  = g;
      e.res = sqmul(recomb(req_x[g*SW +: SW]), recomb(req_y[g*SW +: SW]));
      e.due = cyc + int'(LAT) + 1;
      exp_q.push_back(e);
      m_ptr = (g + 1) % NREQ;
    end
    m_state = nstate;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_rdy), 32'd0);
    chk({tag, "_rnd_ready"}, 32'(rnd_rdy), 32'd0);
    chk({tag, "_mul_x"}, 32'(mul_x), 32'd0);
    chk({tag, "_mul_y"}, 32'(mul_y), 32'd0);
    chk({tag, "_mul_z"}, 32'(mul_z), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_vld), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_q"}, 32'(rsp_q), 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    drive(1'b1, 2'b11, 1'b1, 1'b1);
    #2;
    chk_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request from req0: X=5, Y=3
    drive(1'b1, 2'b00, 1'b1, 1'b1);
    tick();
    drive(1'b1, 2'b01, 1'b1, 1'b1);
    set_req(0, 4'h5, 4'h3);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 1'b1, 1'b1);
      tick();
    end

    // Both requesters held valid
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'b11, 1'b1, 1'b1);
      tick();
    end

    // Randomness withheld for three cycles, then offered
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b11, 1'b1, 1'b1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b11, (i == 3), 1'b1);
      tick();
    end

    // Response port blocked: buffer fills, then drains in order
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b11, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b11, 1'b1, 1'b1);
      tick();
    end

    // Enable dropped with work in flight
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 1'b1, 1'b1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b01, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b11, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11, 1'b1, (i > 0));
      tick();
    end

    // Asynchronous reset in the middle of an issue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 2'b11, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    exp_q.delete();
    m_state = 0;
    m_ptr   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 1'b1, 1'b1);
      tick();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 16) != 0, NREQ'($urandom), ($urandom % 4) != 0, ($urandom % 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
